// File: rtl/cunchuqi_pkg.sv
// Shared constants and reset-pattern helper for the cunchuqi bring-up memory.
package cunchuqi_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int BYTE_W = 8;

  // Byte k of word i is {k, i}, so every lane of every word is distinguishable on the LEDs.
  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < DATA_W / BYTE_W; k++) begin
      w[k*BYTE_W +: BYTE_W] = {k[1:0], idx};
    end
    return w;
  endfunction

endpackage

// File: rtl/cunchuqi_ram.sv
// 64 x 32 flip-flop array: asynchronous reset to the init pattern, synchronous write, combinational read.
module cunchuqi_ram
  import cunchuqi_pkg::*;
#(
  parameter logic [DATA_W-1:0] WRITE_DATA = 32'h12345678
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Flops rather than block RAM so the whole array can be reloaded asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= init_word(ADDR_W'(i));
      end
    end else if (we_i) begin
      mem_q[addr_i] <= WRITE_DATA;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cunchuqi.sv
// Memory-stage bring-up top: switch-addressed word, byte-lane select, registered LED byte.
module cunchuqi
  import cunchuqi_pkg::*;
#(
  parameter logic [DATA_W-1:0] WRITE_DATA = 32'h12345678
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:2]        mem_arr,
  input  logic [1:0]        sw,
  input  logic              mem_write,
  output logic [BYTE_W-1:0] led
);

  logic [DATA_W-1:0] rdata;
  logic [BYTE_W-1:0] led_d;
  logic [BYTE_W-1:0] led_q;

  cunchuqi_ram #(
    .WRITE_DATA(WRITE_DATA)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .addr_i (mem_arr),
    .we_i   (mem_write),
    .rdata_o(rdata)
  );

  always_comb begin
    led_d = rdata[BYTE_W-1:0];
    unique case (sw)
      2'b00: led_d = rdata[7:0];
      2'b01: led_d = rdata[15:8];
      2'b10: led_d = rdata[23:16];
      2'b11: led_d = rdata[31:24];
      default: led_d = rdata[7:0];
    endcase
  end

  // The lane is sampled from the pre-write array, which gives read-before-write on collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_cunchuqi.sv
// Scoreboard bench: default and overridden WRITE_DATA instances against an array model of the memory.
module tb_cunchuqi;

  localparam logic [31:0] WD0 = 32'h12345678;
  localparam logic [31:0] WD1 = 32'hA5A55A5A;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:2] mem_arr;
  logic [1:0] sw;
  logic       mem_write;
  logic [7:0] led;
  logic [7:0] ledAlt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] exp0;
    logic [7:0] exp1;
    string      tag;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] model0 [64];
  logic [31:0] model1 [64];

  always #5 clk = ~clk;

  cunchuqi dut (
    .clk      (clk),
    .rst      (rst),
    .mem_arr  (mem_arr),
    .sw       (sw),
    .mem_write(mem_write),
    .led      (led)
  );

  cunchuqi #(
    .WRITE_DATA(WD1)
  ) dutAlt (
    .clk      (clk),
    .rst      (rst),
    .mem_arr  (mem_arr),
    .sw       (sw),
    .mem_write(mem_write),
    .led      (ledAlt)
  );

  function automatic logic [31:0] patternWord(int i);
    longint unsigned w = 0;
    for (int k = 0; k < 4; k++) w = w + ((longint'(k) * 64 + longint'(i)) << (8 * k));
    return w[31:0];
  endfunction

  function automatic logic [7:0] laneByte(logic [31:0] w, int lane);
    logic [31:0] s;
    s = w >> (8 * lane);
    return s[7:0];
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 64; i++) begin
      model0[i] = patternWord(i);
      model1[i] = patternWord(i);
    end
  endtask

  task automatic checkOutput(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: led=%02h expected=%02h", name, act, exp);
    end
  endtask

  // One clock of switch settings; expected LED bytes come from the model before it applies the write.
  task automatic applyStimulus(int addr, int lane, bit we, string tag);
    exp_t e;
    @(negedge clk);
    mem_arr   = 6'(addr);
    sw        = 2'(lane);
    mem_write = we;
    e.exp0 = laneByte(model0[addr], lane);
    e.exp1 = laneByte(model1[addr], lane);
    e.tag  = tag;
    if (we) begin
      model0[addr] = WD0;
      model1[addr] = WD1;
    end
    expQ.push_back(e);
  endtask

  task automatic pulseReset(string tag);
    @(negedge clk);
    #2;
    rst       = 1'b1;
    mem_write = 1'b0;
    #1;
    checkOutput({tag, "_async"}, led, 8'h00);
    checkOutput({tag, "_asyncAlt"}, ledAlt, 8'h00);
    @(posedge clk);
    #1;
    checkOutput({tag, "_held"}, led, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    resetModel();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e.tag, led, e.exp0);
        checkOutput({e.tag, "_alt"}, ledAlt, e.exp1);
      end
    end
  end

  initial begin : stimulus
    rst       = 1'b1;
    mem_arr   = 6'd0;
    sw        = 2'b01;
    mem_write = 1'b0;
    resetModel();
    #12;
    checkOutput("resetInit", led, 8'h00);
    checkOutput("resetInitAlt", ledAlt, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 1, 0, "rstRelease");
    pulseReset("rstMid");
    applyStimulus(0, 1, 0, "rstRelease2");

    for (int l = 0; l < 4; l++) applyStimulus(1, l, 0, "sweepW1");
    applyStimulus(63, 3, 0, "sweepW63");

    for (int c = 0; c < 10; c++) applyStimulus(0, 0, 1, "writeW0");
    for (int l = 0; l < 4; l++) applyStimulus(0, l, 0, "readW0");
    applyStimulus(1, 0, 0, "untouchedW1");

    applyStimulus(5, 0, 1, "collideOld");
    applyStimulus(5, 0, 0, "collideNew");

    applyStimulus(0, 2, 1, "preRstWrite");
    pulseReset("rstAfterWrite");
    applyStimulus(0, 2, 0, "restoredW0");

    applyStimulus(10, 0, 1, "writeW10");
    applyStimulus(10, 0, 0, "readW10lo");
    applyStimulus(10, 3, 0, "readW10hi");

    for (int n = 0; n < 400; n++) begin
      int a;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) pulseReset("rndRst");
      applyStimulus(a, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), "random");
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: pending=%0d expected=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cunchuqi.md
# cunchuqi

Word-addressed 64 × 32-bit read/write memory with a byte-lane display port, intended for board-level bring-up of the memory stage of the teaching CPU. The address comes from switches as a byte address with bits [7:2] only. A 2-bit switch selects one byte of the addressed word, and that byte drives eight LEDs through a registered output. Writes store a fixed, parameterised 32-bit pattern into the addressed word.

## Interface
Parameters:
- WRITE_DATA, default 32'h12345678: word stored on every write.

Ports (clock and reset first):
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mem_arr  input  [7:2]  word address. These are byte-address bits 7..2, so there are 64 words.
- sw  input  [1:0]  byte-lane select. 00 selects bits [7:0]; 11 selects bits [31:24].
- mem_write  input  1  write enable, level-sensitive.
- led  output  [7:0]  selected byte of the addressed word, registered.

## Operation
- Storage: mem[0..63], each 32 bits.
- Reset contents, loaded while rst is high: byte k of word i equals {k[1:0], i[5:0]}.
  - Word 0 = 32'hC0804000.
  - Word 1 = 32'hC1814101.
  - Word 63 = 32'hFFBF7F3F.
- Write: on each rising clk with mem_write=1 and rst=0, mem[mem_arr] <= WRITE_DATA.
  - Writes repeat every cycle while mem_write is held high. Repeated writes are idempotent.
- Read: on each rising clk with rst=0, led <= byte sw of mem[mem_arr].
  - Reads happen every cycle, regardless of mem_write.
- Read/write collision (same cycle, same address): led takes the pre-write contents (read-before-write). The new data appears on the following cycle.
- The address and sw are used unmodified. There is no out-of-range case.
- There are no unknown values: every word is defined from reset.

## Timing
- rst asserted: led = 8'h00 immediately, without waiting for clk. The memory takes the reset pattern immediately. Both hold while rst is high.
- rst deassertion is synchronised by the system. The first edge after deassertion performs a normal read and write.
- Read latency: led reflects the mem_arr and sw sampled at edge N, valid after edge N.
- Write-to-read latency:
  - A write at edge N is visible in led after edge N+1 when the address is held.
  - A different address read at edge N+1 is unaffected by the write.
- Reset mid-operation: any write in progress is discarded. All words revert to the reset pattern.
- No handshake. Inputs are treated as static switch levels sampled each edge.

## Structure
- Shared package cunchuqi_pkg holds:
  - constants ADDR_W=6, DATA_W=32, DEPTH=64, BYTE_W=8;
  - function init_word(i) returning the reset pattern for word i.
- One sub-module, cunchuqi_ram. It holds the 64×32 array with asynchronous reset init and a synchronous write port. It provides a combinational read of mem[addr].
- The top level holds:
  - the byte-lane mux on sw;
  - the led output register with asynchronous reset.
- The array is built from flip-flops, not inferred block RAM, because of the asynchronous reset init.

## Test plan
- Reset check: pulse rst mid-cycle with mem_arr=0, sw=01 → led=8'h00 during reset. After release and one edge, led=8'h40.
- Reset pattern sweep: mem_arr=1 with sw=00/01/10/11, one edge each → led=01, 41, 81, C1. mem_arr=63, sw=11 → FF.
- Write then read, default WRITE_DATA:
  - mem_arr=0, mem_write=1 for 10 cycles, then mem_write=0.
  - sw=00/01/10/11 → led=78, 56, 34, 12.
  - Then mem_arr=1, sw=00 → 01, confirming word 1 is untouched.
- Collision: mem_arr=5, sw=00, mem_write=1 for exactly one edge.
  - led after that edge = 05 (old data).
  - After the next edge with mem_write=0, led = 78.
- Reset after writes: write word 0, then pulse rst, then read mem_arr=0, sw=10 → 80, confirming the reset pattern is restored.
- Parameter override: WRITE_DATA=32'hA5A5_5A5A. Write word 10, then read sw=00 → 5A and sw=11 → A5.
